// File: rtl/sc_datamem_mmio.sv
// Data memory with byte-enable RAM and an MMIO window for the single-cycle CPU:
// hex/LED outputs, switch/key inputs, key edge capture, compare timer and irq.
module sc_datamem_mmio #(
    parameter int          ADDR_W  = 5,
    parameter int          NUM_HEX = 6,
    parameter int          LED_W   = 10,
    parameter int          SW_W    = 10,
    parameter int          KEY_W   = 3,
    parameter logic [23:0] IO_BASE = 24'hffffff
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          datain,
    input  logic                 we,
    input  logic [3:0]           be,
    output logic [31:0]          dataout,
    input  logic [SW_W-1:0]      sw,
    input  logic [KEY_W-1:0]     key,
    output logic [7*NUM_HEX-1:0] hex,
    output logic [LED_W-1:0]     led,
    output logic                 irq
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]                 mem [DEPTH];
    logic [ADDR_W-1:0]           idx;
    logic [7:0]                  off;
    logic                        io_sel, io_wr, ram_wr;

    logic [NUM_HEX-1:0][6:0]     hex_r;
    logic [LED_W-1:0]            led_r;
    logic [KEY_W-1:0]            ks1, ks2, ks3, key_edge, ke_clr, ke_set;
    logic [31:0]                 count, compare;
    logic [3:0]                  ctrl;
    logic                        status, match, st_clr;
    logic                        unused_ok;

    assign idx    = addr[ADDR_W+1:2];
    assign off    = addr[7:0];
    assign io_sel = (addr[31:8] == IO_BASE);
    assign io_wr  = we & io_sel;
    assign ram_wr = we & ~io_sel;
    assign unused_ok = ^addr[1:0];

    // RAM is intentionally left out of reset so data survives a CPU reset
    always_ff @(posedge clock) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= datain[8*b +: 8];
        end
    end

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        always_ff @(posedge clock) begin
            if (reset)                          hex_r[i] <= '1;
            else if (io_wr && off == 8'(16*i))  hex_r[i] <= datain[6:0];
        end
    end

    assign hex = hex_r;
    assign led = led_r;

    always_ff @(posedge clock) begin
        if (reset)                       led_r <= '0;
        else if (io_wr && off == 8'h60)  led_r <= datain[LED_W-1:0];
    end

    // Key synchroniser and previous-sample flops idle high so reset never fakes an edge
    assign ke_set = ks3 & ~ks2;
    assign ke_clr = (io_wr && off == 8'h90) ? datain[KEY_W-1:0] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            ks1      <= '1;
            ks2      <= '1;
            ks3      <= '1;
            key_edge <= '0;
        end else begin
            ks1      <= key;
            ks2      <= ks1;
            ks3      <= ks2;
            key_edge <= (key_edge & ~ke_clr) | ke_set;
        end
    end

    assign match  = ctrl[0] && (count == compare);
    assign st_clr = io_wr && off == 8'hD0 && datain[0];

    // CPU write to COUNT beats both the increment and the auto-reload
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            compare <= '1;
            ctrl    <= '0;
            status  <= 1'b0;
        end else begin
            if (io_wr && off == 8'hA0)  count <= datain;
            else if (match && ctrl[2])  count <= '0;
            else if (ctrl[0])           count <= count + 32'd1;
            if (io_wr && off == 8'hB0)  compare <= datain;
            if (io_wr && off == 8'hC0)  ctrl <= datain[3:0];
            status <= (status & ~st_clr) | match;
        end
    end

    assign irq = (ctrl[1] & status) | (ctrl[3] & |key_edge);

    always_comb begin
        dataout = '0;
        if (!io_sel) begin
            dataout = mem[idx];
        end else begin
            for (int i = 0; i < NUM_HEX; i++)
                if (off == 8'(16*i)) dataout = 32'(hex_r[i]);
            case (off)
                8'h60:   dataout = 32'(led_r);
                8'h70:   dataout = 32'(ks2);
                8'h80:   dataout = 32'(sw);
                8'h90:   dataout = 32'(key_edge);
                8'hA0:   dataout = count;
                8'hB0:   dataout = compare;
                8'hC0:   dataout = 32'(ctrl);
                8'hD0:   dataout = 32'(status);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_datamem_mmio.sv
// Directed self-checking bench for sc_datamem_mmio: RAM byte writes, MMIO
// registers, key edge capture, timer match/reload/wrap and irq.
module tb_sc_datamem_mmio;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr, datain, dataout;
    logic        we;
    logic [3:0]  be;
    logic [9:0]  sw;
    logic [2:0]  key;
    logic [41:0] hex;
    logic [9:0]  led;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] d;

    localparam logic [31:0] IO = 32'hffffff00;

    sc_datamem_mmio dut (
        .clock(clock), .reset(reset), .addr(addr), .datain(datain), .we(we),
        .be(be), .dataout(dataout), .sw(sw), .key(key), .hex(hex), .led(led),
        .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] b);
        addr = a; datain = v; be = b; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a; we = 1'b0;
        #1;
        v = dataout;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; addr = '0; datain = '0; we = 1'b0; be = '0;
        sw = 10'h2A5; key = 3'b111;
        tick(); tick();
        reset = 1'b0;

        // reset state
        chk("rst_hex", 64'(hex), 64'h3FF_FFFF_FFFF);
        chk("rst_led", 64'(led), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        rd(IO | 32'hA0, d); chk("rst_count", 64'(d), 64'h0);
        rd(IO | 32'hB0, d); chk("rst_compare", 64'(d), 64'hFFFFFFFF);
        rd(IO | 32'hC0, d); chk("rst_ctrl", 64'(d), 64'h0);
        rd(IO | 32'hD0, d); chk("rst_status", 64'(d), 64'h0);
        rd(IO | 32'h90, d); chk("rst_keyedge", 64'(d), 64'h0);

        // RAM byte enables, aliasing, I/O writes not reaching RAM
        wr(32'h0, 32'h12345678, 4'b1111);
        wr(32'h0, 32'h000000AB, 4'b0001);
        rd(32'h0, d);  chk("ram_be", 64'(d), 64'h123456AB);
        rd(32'h80, d); chk("ram_alias", 64'(d), 64'h123456AB);
        wr(32'h4, 32'hFFFFFFFF, 4'b1111);
        wr(32'h4, 32'h00CD0000, 4'b0100);
        rd(32'h4, d);  chk("ram_byte2", 64'(d), 64'hFFCDFFFF);
        wr(IO | 32'h00, 32'h00000055, 4'b0000);
        rd(32'h0, d);  chk("ram_io_iso", 64'(d), 64'h123456AB);
        rd(IO | 32'h00, d); chk("hex0_rd", 64'(d), 64'h55);

        // HEX / LED / SW / unused offsets
        wr(IO | 32'h20, 32'h40, 4'b0000);
        chk("hex2_out", 64'(hex[20:14]), 64'h40);
        rd(IO | 32'h20, d); chk("hex2_rd", 64'(d), 64'h40);
        wr(IO | 32'h60, 32'h3FF, 4'b0000);
        chk("led_out", 64'(led), 64'h3FF);
        wr(IO | 32'h60, 32'hFFFFFFFF, 4'b0000);
        rd(IO | 32'h60, d); chk("led_trunc", 64'(d), 64'h3FF);
        rd(IO | 32'h80, d); chk("sw_rd", 64'(d), 64'h2A5);
        rd(IO | 32'hE0, d); chk("unused_E0", 64'(d), 64'h0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_hex", 64'(hex), 64'h3FF_FFFF_FFFF);
        chk("rst2_led", 64'(led), 64'h0);
        rd(32'h0, d); chk("ram_keep", 64'(d), 64'h123456AB);

        // key edge capture
        key = 3'b101;
        tick(); tick();
        rd(IO | 32'h90, d); chk("key_2edges", 64'(d), 64'h0);
        tick();
        rd(IO | 32'h90, d); chk("key_3edges", 64'(d), 64'h2);
        rd(IO | 32'h70, d); chk("key_level", 64'(d), 64'h5);
        wr(IO | 32'hC0, 32'h8, 4'b0000);
        chk("key_irq", 64'(irq), 64'h1);
        wr(IO | 32'h90, 32'h2, 4'b0000);
        rd(IO | 32'h90, d); chk("key_w1c", 64'(d), 64'h0);
        chk("key_irq_off", 64'(irq), 64'h0);
        key = 3'b111;
        tick(); tick(); tick();
        rd(IO | 32'h90, d); chk("key_release", 64'(d), 64'h0);
        key = 3'b101;
        tick(); tick();
        wr(IO | 32'h90, 32'h2, 4'b0000);
        rd(IO | 32'h90, d); chk("key_set_wins", 64'(d), 64'h2);
        wr(IO | 32'hC0, 32'h0, 4'b0000);

        // timer with auto-reload and irq
        wr(IO | 32'hB0, 32'd5, 4'b0000);
        wr(IO | 32'hC0, 32'h7, 4'b0000);
        repeat (5) tick();
        rd(IO | 32'hA0, d); chk("tmr_at5", 64'(d), 64'd5);
        rd(IO | 32'hD0, d); chk("tmr_pre_st", 64'(d), 64'h0);
        chk("tmr_pre_irq", 64'(irq), 64'h0);
        tick();
        rd(IO | 32'hD0, d); chk("tmr_match_st", 64'(d), 64'h1);
        rd(IO | 32'hA0, d); chk("tmr_reload", 64'(d), 64'h0);
        chk("tmr_irq", 64'(irq), 64'h1);
        reset = 1'b1; tick(); reset = 1'b0;
        rd(IO | 32'hA0, d); chk("rst3_count", 64'(d), 64'h0);
        rd(IO | 32'hD0, d); chk("rst3_status", 64'(d), 64'h0);
        chk("rst3_irq", 64'(irq), 64'h0);

        // match without reload, then W1C drops irq
        wr(IO | 32'hB0, 32'd2, 4'b0000);
        wr(IO | 32'hC0, 32'h3, 4'b0000);
        tick(); tick(); tick();
        chk("st_irq_on", 64'(irq), 64'h1);
        rd(IO | 32'hA0, d); chk("noreload_cnt", 64'(d), 64'd3);
        wr(IO | 32'hD0, 32'h1, 4'b0000);
        chk("st_irq_off", 64'(irq), 64'h0);
        rd(IO | 32'hA0, d); chk("cnt_after_clr", 64'(d), 64'd4);

        // wrap at 2^32 and COUNT write beating a match edge
        reset = 1'b1; tick(); reset = 1'b0;
        wr(IO | 32'hC0, 32'h1, 4'b0000);
        wr(IO | 32'hA0, 32'hFFFFFFFE, 4'b0000);
        tick(); tick();
        rd(IO | 32'hA0, d); chk("wrap_cnt", 64'(d), 64'h0);
        rd(IO | 32'hD0, d); chk("wrap_st", 64'(d), 64'h1);
        chk("wrap_noirq", 64'(irq), 64'h0);
        wr(IO | 32'hC0, 32'h5, 4'b0000);
        wr(IO | 32'hD0, 32'h1, 4'b0000);
        wr(IO | 32'hA0, 32'hFFFFFFFF, 4'b0000);
        wr(IO | 32'hA0, 32'h00001234, 4'b0000);
        rd(IO | 32'hA0, d); chk("wr_beats_match", 64'(d), 64'h1234);
        rd(IO | 32'hD0, d); chk("wr_match_st", 64'(d), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sc_datamem_mmio.md
# sc_datamem_mmio

Parametrised data memory with a memory-mapped I/O window for the single-cycle CPU. It takes over the data-port role: word-addressed RAM with byte-enable writes, plus hex/LED outputs and switch/key inputs. It adds key edge capture, a compare timer and an interrupt line. Everything runs on the CPU clock: writes commit on the rising edge and reads are combinational, so no derived memory clock is needed.

## Interface
- ADDR_W, 5: RAM word-address bits; depth = 2^ADDR_W words, indexed by addr[ADDR_W+1:2].
- NUM_HEX, 6: seven-segment digits, 1..6.
- LED_W, 10: LED width, 1..32.
- SW_W, 10: switch width, 1..32.
- KEY_W, 3: pushbutton width, 1..8.
- IO_BASE, 24'hffffff: addr[31:8] value selecting the I/O window.
- clock  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from ALU.
- datain  in  32  store data.
- we  in  1  store strobe.
- be  in  4  byte enables for RAM stores; be[0] = bits 7:0.
- dataout  out  32  load data, combinational.
- sw  in  SW_W  switches, level, no synchronisation.
- key  in  KEY_W  pushbuttons, active-low, asynchronous.
- hex  out  7*NUM_HEX  segments, active-low; digit i occupies bits 7i+6:7i.
- led  out  LED_W  LEDs, active-high.
- irq  out  1  level interrupt request.

## Operation
- io_sel = (addr[31:8] == IO_BASE). RAM write fires when we & ~io_sel. It writes the bytes selected by be at the rising edge. RAM contents are not reset.
- I/O writes fire when we & io_sel. They ignore be and take the full datain, truncated to the register width.
- I/O map, offset = addr[7:0]; other offsets read 0 and ignore writes:
  - 0x00+0x10*i: HEX i, RW, 7 bits, for i < NUM_HEX.
  - 0x60: LED, RW.
  - 0x70: KEY level, RO, zero-extended synchronised key.
  - 0x80: SW, RO, zero-extended sw.
  - 0x90: KEY_EDGE, RW1C; bit k is sticky and is set when synchronised key[k] goes 1→0.
  - 0xA0: COUNT, RW, 32-bit timer.
  - 0xB0: COMPARE, RW.
  - 0xC0: CTRL, RW. Bit 0 = timer enable, bit 1 = timer irq enable, bit 2 = auto-reload, bit 3 = key irq enable.
  - 0xD0: STATUS, RW1C. Bit 0 = match, sticky.
- Key path:
  - Two-flop synchroniser ks1→ks2, then ks3 holds the previous ks2.
  - Edge is detected as ks3 & ~ks2.
  - The synchroniser and previous-sample flops reset to all-ones, so no spurious edge appears after reset.
- Timer:
  - While CTRL[0] is set, COUNT increments by 1 each cycle, mod 2^32.
  - When COUNT == COMPARE with CTRL[0] set, STATUS[0] sets at that edge.
  - On the same edge, COUNT loads 0 if CTRL[2] is set; otherwise it increments normally.
- irq = (CTRL[1] & STATUS[0]) | (CTRL[3] & |KEY_EDGE). It is registered-free, a combinational OR of flops.
- Simultaneous events:
  - A CPU write to COUNT beats both increment and reload.
  - For STATUS and KEY_EDGE, a hardware set in the same cycle as a W1C wins, so the bit stays 1.
  - A write to CTRL takes effect from the next cycle's count decision.
- dataout is mem[addr[ADDR_W+1:2]] when ~io_sel, else the mapped register. RAM aliases above 2^ADDR_W words.

## Timing
- Load data is valid in the same cycle as addr. Store data is visible to a load in the next cycle.
- Key latency: key low, then a 1 appears in KEY_EDGE after exactly 3 rising edges with key stable.
- A match at COUNT == C sets STATUS[0] at that edge; irq rises in the following cycle if CTRL[1] is set.
- Reset values:
  - hex all 1s (blank); led 0.
  - COUNT 0; COMPARE 32'hffffffff; CTRL 0; STATUS 0; KEY_EDGE 0.
  - irq 0.
- Reset mid-count stops the timer and clears all sticky bits on that edge. RAM holds its data.

## Test plan
- Store 32'h12345678 to 0x0 with be=4'b1111, then store 32'hAB to 0x0 with be=4'b0001 → load 0x0 returns 32'h123456AB. Address 0x80 aliases word 0 when ADDR_W=5.
- Write 0x40 to 0xffffff20 and 0x3FF to 0xffffff60 → hex[20:14]=7'h40, led=10'h3FF. Pulse reset → hex all 1s, led 0.
- Drive key[1] low, held → KEY_EDGE reads 3'b010 after 3 edges. Write 3'b010 to 0x90 → reads 0. Repeat with the clear in the same cycle as a new edge → stays 1.
- COMPARE=5, CTRL=4'b0111 → STATUS[0]=1 at the COUNT==5 edge, COUNT reads 0 next cycle, irq=1 one cycle after the match.
- CTRL=1, COMPARE=32'hffffffff, COUNT written 32'hfffffffe → COUNT wraps to 0 and STATUS[0] sets. A COUNT write coinciding with a match edge loads the written value.
- Set STATUS[0], then clear it via W1C while no match occurs → irq falls. Read offsets 0xE0 and 0x60+ unused bits → 0.
